// File: rtl/padder.sv
`default_nettype none
// ============================================================================
//  Module   : padder
//  Function : Packs 32-bit message words into 576-bit rate blocks and applies
//             pad10*1 padding, handing full blocks to the permutation core.
//  Revision : 1.0 - initial release
// ============================================================================
module padder (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in,
  input  logic         in_ready,
  input  logic         is_last,
  input  logic [1:0]   byte_num,
  output logic         buffer_full,
  output logic [575:0] out,
  output logic         out_ready,
  input  logic         f_ack
);

  localparam logic [4:0] C_BLOCK_WORDS = 5'd18;
  localparam logic [4:0] C_LAST_SLOT   = 5'd17;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_PAD    = 1'b1
  } state_t;

  state_t         r_st;
  logic [4:0]     r_cnt;
  logic           r_done;
  logic [575:0]   r_out;

  logic           w_accept;
  logic           w_update;
  logic           w_padding;
  logic [31:0]    w_pad_word;
  logic [31:0]    w_word;

  assign buffer_full = (r_cnt == C_BLOCK_WORDS);
  assign out_ready   = buffer_full;
  assign out         = r_out;

  assign w_accept  = (r_st == ST_NORMAL) && in_ready && !buffer_full;
  assign w_update  = (w_accept || ((r_st == ST_PAD) && !buffer_full)) && !r_done;
  // The closing bit only belongs to the block carrying the padding, never to a
  // block made purely of message words.
  assign w_padding = (r_st == ST_PAD) || is_last;

  always_comb begin
    case (byte_num)
      2'd0:    w_pad_word = 32'h0100_0000;
      2'd1:    w_pad_word = {in[31:24], 24'h01_0000};
      2'd2:    w_pad_word = {in[31:16], 16'h0100};
      default: w_pad_word = {in[31:8],  8'h01};
    endcase
  end

  always_comb begin
    w_word = in;
    if (r_st == ST_PAD)
      w_word = 32'h0000_0000;
    else if (is_last)
      w_word = w_pad_word;
    if (w_padding && (r_cnt == C_LAST_SLOT))
      w_word = w_word | 32'h0000_0080;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out  <= '0;
      r_cnt  <= '0;
      r_st   <= ST_NORMAL;
      r_done <= 1'b0;
    end else begin
      if (f_ack) begin
        r_cnt <= '0;
      end else if (w_update) begin
        r_out <= {r_out[543:0], w_word};
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_accept && is_last && !f_ack)
        r_st <= ST_PAD;
      if ((r_st == ST_PAD) && buffer_full)
        r_done <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_padder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_padder
//  Function : Scoreboard bench for padder; expected padded blocks are queued
//             when a message is driven and popped whenever a block is offered.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_padder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  in = '0;
  logic         in_ready = 1'b0;
  logic         is_last = 1'b0;
  logic [1:0]   byte_num = '0;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack = 1'b0;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [575:0] exp_q[$];
  bit           lat_pending = 1'b0;
  logic [31:0]  lat_exp = '0;

  always #5 clk = ~clk;

  padder dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_ready   (in_ready),
    .is_last    (is_last),
    .byte_num   (byte_num),
    .buffer_full(buffer_full),
    .out        (out),
    .out_ready  (out_ready),
    .f_ack      (f_ack)
  );

  task automatic chk(input string tag, input logic [575:0] act, input logic [575:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Core stand-in: compare every offered block, then acknowledge it.
  initial begin
    forever begin
      @(negedge clk);
      if (f_ack) begin
        f_ack = 1'b0;
      end else if (out_ready) begin
        if (exp_q.size() == 0)
          chk("extra_block", 576'd1, 576'd0);
        else
          chk("block", out, exp_q.pop_front());
        f_ack = 1'b1;
      end
    end
  end

  task automatic lat_poll();
    if (lat_pending) begin
      chk("latency_word0", {544'd0, out[31:0]}, {544'd0, lat_exp});
      lat_pending = 1'b0;
    end
  endtask

  // Holds the word until it is presented on a cycle the buffer is not full.
  task automatic drive_word(input logic [31:0] w, input bit last, input logic [1:0] bn);
    int waited;
    waited = 0;
    forever begin
      @(negedge clk);
      lat_poll();
      in       = w;
      in_ready = 1'b1;
      is_last  = last;
      byte_num = bn;
      if (!buffer_full) break;
      waited++;
      if (waited > 100) begin
        chk("stall_timeout", 576'd1, 576'd0);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    in_ready    = 1'b0;
    is_last     = 1'b0;
    lat_pending = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_out_ready", {575'd0, out_ready}, 576'd0);
    chk("rst_buffer_full", {575'd0, buffer_full}, 576'd0);
    chk("rst_out", out, 576'd0);
  endtask

  task automatic send_msg(input int n_full, input bit incr, input logic [1:0] bn,
                          input logic [31:0] last_w);
    logic [31:0]  words[$];
    logic [31:0]  padq[$];
    logic [31:0]  pw;
    logic [575:0] blk;
    int           nb;
    int           wait_cyc;
    nb = int'(bn);
    for (int i = 0; i < n_full; i++)
      words.push_back(incr ? 32'(i) : $urandom());
    // Reference pad10*1: keep nb message bytes, append 0x01, zero-fill the
    // rest of the block, set the top bit of the last byte of the block.
    padq = words;
    pw = '0;
    for (int b = 0; b < nb; b++)
      pw[31-8*b -: 8] = last_w[31-8*b -: 8];
    pw[31-8*nb -: 8] = 8'h01;
    padq.push_back(pw);
    while (padq.size() % 18 != 0)
      padq.push_back(32'h0);
    padq[padq.size()-1] |= 32'h0000_0080;
    for (int k = 0; k < padq.size() / 18; k++) begin
      blk = '0;
      for (int j = 0; j < 18; j++)
        blk = {blk[543:0], padq[k*18+j]};
      exp_q.push_back(blk);
    end

    for (int i = 0; i < n_full; i++) begin
      drive_word(words[i], 1'b0, 2'd0);
      if (i == 0) begin
        lat_pending = 1'b1;
        lat_exp     = padq[0];
      end
    end
    drive_word(last_w, 1'b1, bn);
    if (n_full == 0) begin
      lat_pending = 1'b1;
      lat_exp     = padq[0];
    end
    @(negedge clk);
    lat_poll();
    in_ready = 1'b0;
    is_last  = 1'b0;

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 400) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0)
      chk("drain_timeout", 576'(exp_q.size()), 576'd0);
    repeat (25) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    do_reset();
    // 19 counting words: first block 0..0x11, the 19th stalls until acked.
    send_msg(19, 1'b1, 2'd1, 32'hDEAD_BEEF);

    do_reset();
    send_msg(0, 1'b0, 2'd2, 32'h1122_3344);

    do_reset();
    // Pad word lands in the final slot together with the closing bit.
    send_msg(17, 1'b0, 2'd0, 32'h5555_5555);

    do_reset();
    send_msg(18, 1'b0, 2'd3, 32'hAABB_CCDD);

    do_reset();
    // Message ends exactly on a block boundary: a whole padding block follows.
    send_msg(18, 1'b0, 2'd0, 32'h0);

    do_reset();
    for (int i = 0; i < 5; i++)
      drive_word($urandom(), 1'b0, 2'd0);
    @(negedge clk);
    in_ready = 1'b0;
    do_reset();
    send_msg(3, 1'b0, 2'd1, 32'h7788_99AA);

    do_reset();
    send_msg(35, 1'b0, 2'd3, 32'h0123_4567);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/padder.md
PADDER -- requirements
Module: padder

Interface
REQ-001 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit, a synchronous, active-low reset: 0 = reset, sampled on the rising edge of clk.
REQ-003 The module SHALL have port in, input, 32 bits, the message word, with the first message byte in in[31:24].
REQ-004 The module SHALL have port in_ready, input, 1 bit, meaning `in` is valid this cycle.
REQ-005 The module SHALL have port is_last, input, 1 bit, marking the final (possibly partial) message word.
REQ-006 The module SHALL have port byte_num, input, 2 bits, giving the number of valid bytes (0..3) in the final word; it is meaningful only when is_last=1.
REQ-007 The module SHALL have port buffer_full, output, 1 bit, meaning the block buffer holds 18 words and the upstream source must stall.
REQ-008 The module SHALL have port out, output, 576 bits, the padded rate block, with word 0 in out[575:544].
REQ-009 The module SHALL have port out_ready, output, 1 bit, meaning `out` is a complete block for the permutation core.
REQ-010 The module SHALL have port f_ack, input, 1 bit, meaning the core consumed `out` this cycle.

Function
REQ-011 The module SHALL hold these registers: out (576 bits), word count cnt (0..18), padding state st (NORMAL/PAD), and done flag.
REQ-012 The module SHALL drive buffer_full = (cnt==18) and out_ready = buffer_full.
REQ-013 The module SHALL assert accept = st==NORMAL & in_ready & ~buffer_full.
REQ-014 The module SHALL assert update = (accept | (st==PAD & ~buffer_full)) & ~done.
REQ-015 On update, the module SHALL set out <= {out[543:0], w} and cnt <= cnt+1.
REQ-016 In NORMAL with is_last=0, w SHALL equal in.
REQ-017 In NORMAL with is_last=1, w SHALL be the pad word: byte_num 0 -> 0x01000000; 1 -> {in[31:24],0x010000}; 2 -> {in[31:16],0x0100}; 3 -> {in[31:8],0x01}.
REQ-018 In PAD, w SHALL equal 0x00000000.
REQ-019 When cnt==17 (the final word slot of the block), w SHALL be OR'ed with 0x00000080 (pad10*1 closing bit); if the pad word lands in slot 17, both bits SHALL be present (e.g. byte_num 0 -> 0x01000080).
REQ-020 A cycle with accept & is_last SHALL move st NORMAL->PAD; st SHALL never return to NORMAL except by reset.
REQ-021 The module SHALL set done <= 1 when st==PAD and buffer_full=1; done blocks all further updates until reset.
REQ-022 f_ack=1 SHALL set cnt <= 0 that cycle and take priority over update; out SHALL keep its value.
REQ-023 While buffer_full=1, the module SHALL ignore in_ready; words presented then are not consumed and the source must hold them.
REQ-024 If the message ends exactly at a block boundary (is_last with byte_num 0 in slot 0 after f_ack), the module SHALL emit one extra block 0x01000000, 16 zero words, and 0x00000080.
REQ-025 Latency: a word accepted in cycle N SHALL be visible in out[31:0] and cnt in cycle N+1; out_ready SHALL rise in the cycle after the 18th update.

Reset
REQ-026 On a clock edge with reset=0, the module SHALL set out=0, cnt=0, st=NORMAL, done=0; hence buffer_full=0 and out_ready=0 in the following cycle.
REQ-027 Reset SHALL take priority over f_ack, update, and all other inputs.
REQ-028 Reset mid-block SHALL discard the partial block entirely.

Verification
REQ-029 Scenario: 18 words 0x00000000..0x00000011 with is_last=0 -> out_ready=1 after the 18th, out[575:544]=0, out[31:0]=0x00000011; a 19th word is stalled until f_ack.
REQ-030 Scenario: one word 0x11223344, is_last=1, byte_num=2 -> out words = 0x11220100, 16 x 0, 0x00000080; done=1.
REQ-031 Scenario: 17 full words, then is_last=1, byte_num=0 -> word 17 = 0x01000080; no second block is produced.
REQ-032 Scenario: 18 full words, f_ack, then is_last=1, byte_num=3, in=0xAABBCCDD -> block 2 word 0 = 0xAABBCC01 and word 17 = 0x00000080.
REQ-033 Scenario: f_ack asserted in the same cycle as a valid in_ready while full -> cnt=0 next cycle and the word is not consumed.
REQ-034 Scenario: reset=0 asserted after 5 words, then released and a new message sent -> the new block contains no stale words.
